poly_demux5_bank: RTL and testbench

- Write-side counterpart of the 5-to-1 polynomial output multiplexer.
- Receives one polynomial serially, one coefficient per handshake, and assembles it in a staging buffer.
- Commits the complete polynomial atomically into one of five destination slots:
  - slots 0-3: small polynomials, `KYBER_SPOLY_WIDTH` per coefficient;
  - slot 4: normal-size polynomial, `KYBER_R_WIDTH` per coefficient.
- Slot outputs use the same packing as the multiplexer's inputs, so they wire straight into it.

---
 rtl/poly_demux5_bank.sv | 165 ++++++++++++++++
 tb/tb_poly_demux5_bank.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_demux5_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | poly_demux5_bank: serial coefficient loader with atomic commit into one  |
// | of five polynomial slots. Optional range check: SPOLY_RANGE_CHECK_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module poly_demux5_bank #(
  parameter int N       = 256,
  parameter int R_WIDTH = 13,
  parameter int S_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           sel,
  input  logic                 in_valid,
  input  logic [R_WIDTH-1:0]   in_data,
  output logic                 in_ready,
  output logic                 busy,
  output logic                 done,
  output logic [N*S_WIDTH-1:0] slot0,
  output logic [N*S_WIDTH-1:0] slot1,
  output logic [N*S_WIDTH-1:0] slot2,
  output logic [N*S_WIDTH-1:0] slot3,
  output logic [N*R_WIDTH-1:0] slot4,
  output logic                 err
);

  localparam int                 c_CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_count;
  logic [2:0]           r_sel_q;
  logic [N*R_WIDTH-1:0] r_stage;
  logic [N*S_WIDTH-1:0] r_slot0, r_slot1, r_slot2, r_slot3;
  logic [N*R_WIDTH-1:0] r_slot4;
  logic                 r_done;
  logic                 w_start_ok;
  logic                 w_xfer;
  logic                 w_commit;
  logic                 w_in_ready;
  logic                 w_busy;
  logic [N*S_WIDTH-1:0] w_small;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_xfer      = 1'b0;
    w_commit    = 1'b0;
    w_in_ready  = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (sel <= 3'd4)) begin
          w_start_ok  = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        w_xfer     = in_valid;
        if (in_valid && (r_count == c_LAST)) begin
          w_state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_busy      = 1'b1;
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Small slots keep only the low S_WIDTH bits of each staged coefficient.
  for (genvar gi = 0; gi < N; gi++) begin : g_trunc
    assign w_small[gi*S_WIDTH +: S_WIDTH] = r_stage[gi*R_WIDTH +: S_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_sel_q <= 3'd0;
      r_stage <= '0;
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_slot2 <= '0;
      r_slot3 <= '0;
      r_slot4 <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_start_ok) begin
        r_sel_q <= sel;
        r_count <= '0;
      end
      if (w_xfer) begin
        r_stage[r_count*R_WIDTH +: R_WIDTH] <= in_data;
        r_count                             <= r_count + c_CNT_W'(1);
      end
      if (w_commit) begin
        case (r_sel_q)
          3'd0:    r_slot0 <= w_small;
          3'd1:    r_slot1 <= w_small;
          3'd2:    r_slot2 <= w_small;
          3'd3:    r_slot3 <= w_small;
          3'd4:    r_slot4 <= r_stage;
          default: ;
        endcase
      end
    end
  end

`ifdef SPOLY_RANGE_CHECK_EN
  logic r_err;
  logic w_range_bad;

  // Out of range means the value differs from the sign extension of its low bits.
  assign w_range_bad = (in_data != {{(R_WIDTH-S_WIDTH){in_data[S_WIDTH-1]}}, in_data[S_WIDTH-1:0]});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_start_ok) begin
      r_err <= 1'b0;
    end else if (w_xfer && (r_sel_q <= 3'd3) && w_range_bad) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign in_ready = w_in_ready;
  assign busy     = w_busy;
  assign done     = r_done;
  assign slot0    = r_slot0;
  assign slot1    = r_slot1;
  assign slot2    = r_slot2;
  assign slot3    = r_slot3;
  assign slot4    = r_slot4;

endmodule
`default_nettype wire

// File: tb/tb_poly_demux5_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_poly_demux5_bank: randomized bench with a transaction-level model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_poly_demux5_bank;

  localparam int N       = 256;
  localparam int R_WIDTH = 13;
  localparam int S_WIDTH = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [2:0]           sel = 3'd0;
  logic                 in_valid = 1'b0;
  logic [R_WIDTH-1:0]   in_data = '0;
  logic                 in_ready, busy, done, err;
  logic [N*S_WIDTH-1:0] slot0, slot1, slot2, slot3;
  logic [N*R_WIDTH-1:0] slot4;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;
  bit chk_en = 1'b0;

  poly_demux5_bank #(.N(N), .R_WIDTH(R_WIDTH), .S_WIDTH(S_WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .busy(busy), .done(done),
    .slot0(slot0), .slot1(slot1), .slot2(slot2), .slot3(slot3),
    .slot4(slot4), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (transaction level) ----------------
  logic [R_WIDTH-1:0]   m_q[$];
  bit                   m_loading = 1'b0;
  bit                   m_commit  = 1'b0;
  bit                   m_done    = 1'b0;
  bit                   m_err     = 1'b0;
  int                   m_sel     = 0;
  logic [N*S_WIDTH-1:0] m_ps[4];
  logic [N*R_WIDTH-1:0] m_pr = '0;

  function automatic bit fits(input logic [R_WIDTH-1:0] v);
    int sv;
    sv = int'($signed(v));
    return (sv >= -(1 << (S_WIDTH-1))) && (sv < (1 << (S_WIDTH-1)));
  endfunction

  initial begin
    logic [R_WIDTH-1:0] v;
    for (int k = 0; k < 4; k++) m_ps[k] = '0;
    forever begin
      @(posedge clk);
      edge_cnt++;
      if (rst) begin
        m_loading = 1'b0; m_commit = 1'b0; m_done = 1'b0; m_err = 1'b0;
        m_q.delete();
        for (int k = 0; k < 4; k++) m_ps[k] = '0;
        m_pr = '0;
      end else begin
        m_done = 1'b0;
        if (m_commit) begin
          for (int i = 0; i < N; i++) begin
            v = m_q[i];
            if (m_sel == 4) m_pr[i*R_WIDTH +: R_WIDTH] = v;
            else            m_ps[m_sel][i*S_WIDTH +: S_WIDTH] = v[S_WIDTH-1:0];
          end
          m_q.delete();
          m_commit = 1'b0;
          m_done   = 1'b1;
        end else if (m_loading) begin
          if (in_valid) begin
            m_q.push_back(in_data);
            if (m_sel < 4 && !fits(in_data)) m_err = 1'b1;
            if (m_q.size() == N) begin
              m_loading = 1'b0;
              m_commit  = 1'b1;
            end
          end
        end else if (start && sel <= 3'd4) begin
          m_loading = 1'b1;
          m_sel     = int'(sel);
          m_err     = 1'b0;
          m_q.delete();
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk1(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%b exp=%b t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic chk_s(input string nm, input logic [N*S_WIDTH-1:0] a, input logic [N*S_WIDTH-1:0] e);
    int first;
    total++;
    if (a !== e) begin
      bad++;
      first = -1;
      for (int i = 0; i < N; i++)
        if (first < 0 && a[i*S_WIDTH +: S_WIDTH] !== e[i*S_WIDTH +: S_WIDTH]) first = i;
      $display("FAIL %s coef=%0d act=%h exp=%h t=%0t", nm, first,
               a[first*S_WIDTH +: S_WIDTH], e[first*S_WIDTH +: S_WIDTH], $time);
    end
  endtask

  task automatic chk_r(input string nm, input logic [N*R_WIDTH-1:0] a, input logic [N*R_WIDTH-1:0] e);
    int first;
    total++;
    if (a !== e) begin
      bad++;
      first = -1;
      for (int i = 0; i < N; i++)
        if (first < 0 && a[i*R_WIDTH +: R_WIDTH] !== e[i*R_WIDTH +: R_WIDTH]) first = i;
      $display("FAIL %s coef=%0d act=%h exp=%h t=%0t", nm, first,
               a[first*R_WIDTH +: R_WIDTH], e[first*R_WIDTH +: R_WIDTH], $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    logic e_err;
    forever begin
      @(negedge clk);
      if (chk_en) begin
`ifdef SPOLY_RANGE_CHECK_EN
        e_err = m_err;
`else
        e_err = 1'b0;
`endif
        chk1("in_ready", in_ready, m_loading);
        chk1("busy", busy, m_loading | m_commit);
        chk1("done", done, m_done);
        chk1("err", err, e_err);
        chk_s("slot0", slot0, m_ps[0]);
        chk_s("slot1", slot1, m_ps[1]);
        chk_s("slot2", slot2, m_ps[2]);
        chk_s("slot3", slot3, m_ps[3]);
        chk_r("slot4", slot4, m_pr);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [R_WIDTH-1:0] coef(input int mode, input int idx);
    int v;
    v = int'($urandom_range(0, 7)) - 4;
    case (mode)
      0:       return R_WIDTH'(idx);
      1:       return (idx % 2 == 0) ? {R_WIDTH{1'b1}} : R_WIDTH'(2);
      2:       return R_WIDTH'(1);
      3:       return R_WIDTH'($urandom);
      4:       return R_WIDTH'(v);
      5:       return (idx == 7) ? R_WIDTH'(5) : R_WIDTH'(v);
      6:       return (idx == 3) ? R_WIDTH'(2000) : R_WIDTH'(v);
      default: return '0;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge right after the commit edge.
  task automatic xfer(input int s, input int mode, input int vpct, input bit tog,
                      input bit inj, output int lc, output int lat);
    int idx, guard, start_edge;
    bit acc;
    start    = 1'b1;
    sel      = 3'(s);
    in_valid = 1'($urandom_range(0, 1));
    in_data  = R_WIDTH'($urandom);
    tick();
    start_edge = edge_cnt;
    chk1("start_accepted_busy", busy, 1'b1);
    start = 1'b0;
    idx = 0; guard = 0; lc = 0;
    while (idx < N && guard < 8*N) begin
      if (tog) in_valid = (guard % 2 == 1);
      else     in_valid = ($urandom_range(0, 99) < vpct);
      in_data = coef(mode, idx);
      sel     = 3'($urandom_range(0, 7));
      if (inj && guard == N/2) begin start = 1'b1; sel = 3'd1; end
      else start = 1'b0;
      acc = in_valid && in_ready;
      if (in_ready) lc++;
      tick();
      guard++;
      if (acc) idx++;
    end
    if (idx < N) chk_int("xfer_timeout", idx, N);
    start    = 1'($urandom_range(0, 1));
    sel      = 3'($urandom_range(0, 4));
    in_valid = 1'b1;
    in_data  = R_WIDTH'($urandom);
    tick();
    lat = edge_cnt - start_edge;
    chk1("done_after_commit", done, 1'b1);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    int lc, lat, nb;
    logic [R_WIDTH-1:0]   c;
    logic [S_WIDTH-1:0]   cs;
    logic [N*S_WIDTH-1:0] sv1, sv2;

    repeat (2) tick();
    chk_en = 1'b1;
    chk1("rst_busy", busy, 1'b0);
    chk_r("rst_slot4", slot4, '0);
    rst = 1'b0;
    tick();

    // Reset in the middle of a load must leave every slot untouched.
    start = 1'b1; sel = 3'd2;
    tick();
    start = 1'b0; in_valid = 1'b1;
    repeat (10) begin in_data = R_WIDTH'($urandom); tick(); end
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_done", done, 1'b0);
    chk_s("midrst_slot2", slot2, '0);
    tick();
    chk1("midrst_done2", done, 1'b0);

    // Ramp into slot 4 with no stalls.
    xfer(4, 0, 100, 1'b0, 1'b0, lc, lat);
    chk_int("slot4_latency", lat, N + 1);
    nb = 0;
    for (int i = 0; i < N; i++) begin
      c = slot4[i*R_WIDTH +: R_WIDTH];
      if (c != R_WIDTH'(i)) nb++;
    end
    chk_int("slot4_ramp_badcoefs", nb, 0);
    chk_s("slot0_still_zero", slot0, '0);
    chk_s("slot3_still_zero", slot3, '0);

    // Alternating -1/+2 into slot 2, then all ones into slot 0.
    xfer(2, 1, 100, 1'b0, 1'b0, lc, lat);
    nb = 0;
    for (int i = 0; i < N; i++) begin
      cs = slot2[i*S_WIDTH +: S_WIDTH];
      if (cs != ((i % 2 == 0) ? 3'b111 : 3'b010)) nb++;
    end
    chk_int("slot2_alt_badcoefs", nb, 0);
    sv2 = slot2;
    xfer(0, 2, 100, 1'b0, 1'b0, lc, lat);
    nb = 0;
    for (int i = 0; i < N; i++) begin
      cs = slot0[i*S_WIDTH +: S_WIDTH];
      if (cs != 3'b001) nb++;
    end
    chk_int("slot0_ones_badcoefs", nb, 0);
    chk_s("slot2_unchanged", slot2, sv2);

    // Half-rate valid with a stray start/sel=1 injected mid-load.
    sv1 = slot1;
    xfer(3, 0, 100, 1'b1, 1'b1, lc, lat);
    chk_int("slot3_load_cycles", lc, 2*N);
    nb = 0;
    for (int i = 0; i < N; i++) begin
      cs = slot3[i*S_WIDTH +: S_WIDTH];
      if (cs != 3'(i)) nb++;
    end
    chk_int("slot3_badcoefs", nb, 0);
    chk_s("slot1_unchanged", slot1, sv1);

    // Out-of-range select is ignored; a valid start next cycle is taken.
    start = 1'b1; sel = 3'd6;
    tick();
    chk1("badsel_busy", busy, 1'b0);
    chk1("badsel_done", done, 1'b0);
    xfer(1, 5, 100, 1'b0, 1'b0, lc, lat);
    cs = slot1[7*S_WIDTH +: S_WIDTH];
    chk_int("slot1_coef7", int'(cs), 5);
`ifdef SPOLY_RANGE_CHECK_EN
    chk1("err_after_range", err, 1'b1);
`endif
    xfer(4, 6, 100, 1'b0, 1'b0, lc, lat);
    chk1("err_after_slot4", err, 1'b0);
    c = slot4[3*R_WIDTH +: R_WIDTH];
    chk_int("slot4_coef3", int'(c), 2000);

    // Randomized traffic.
    for (int r = 0; r < 10; r++) begin
      repeat ($urandom_range(0, 4)) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = R_WIDTH'($urandom);
        start    = ($urandom_range(0, 3) == 0);
        sel      = 3'($urandom_range(5, 7));
        tick();
      end
      start = 1'b0; in_valid = 1'b0;
      xfer(int'($urandom_range(0, 4)), int'($urandom_range(0, 5)),
           int'($urandom_range(40, 100)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), lc, lat);
    end
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
